tx8b10b_kchar: RTL
==================

Name: tx8b10b_kchar

Overview:
Bit-serial 8b10b line transmitter with control-character (K-code) support and a valid/ready input handshake instead of an internal FIFO. It encodes each accepted byte with the standard 5b6b/3b4b tables and running disparity, then shifts the 10-bit symbol out at CLK_RATE clocks per bit. When no data is offered it sends the fill word. It pairs with the existing receive path for framed links that need SOF/EOF commas.

Parameters:
FILL_WORD_RD0, 10'b0011111010, fill symbol sent when RD=-1 (K28.5-)
FILL_WORD_RD1, 10'b1100000101, fill symbol sent when RD=+1 (K28.5+)
FILL_WORD_FLIP, 1'b1, invert RD after each fill symbol
CLK_RATE, 8, clocks per line bit; must be >=2

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active high
txEnable  in  1  level enable for transmitter
dataIn  in  8  byte to send, HGF EDCBA
isK  in  1  dataIn is a control character
valid  in  1  dataIn/isK valid
ready  out  1  symbol slot available; transfer when valid&ready
kError  out  1  one-cycle pulse: unsupported K code requested
busy  out  1  a symbol is being shifted
rd  out  1  current running disparity (0 = RD-, 1 = RD+)
tx  out  1  serial line output

Behaviour:
- Reset (async): tx=0, ready=0, kError=0, busy=0, rd=0, bit timer=0, bit index=0, state=IDLE.
- States: IDLE, SHIFT.
- IDLE: tx=0, busy=0. If txEnable=1, go to the slot-decision cycle (see below) on the same edge.
- Bit timing: each bit is held CLK_RATE clocks. The symbol is 10 bits, sent in order a,b,c,d,e,i,f,g,h,j. This is symbol bit 9 first, so the fill parameters are sent MSB first.
- Slot decision: ready=1 for exactly one cycle. This cycle is the last clock of bit j, or the first cycle after IDLE with txEnable=1.
  - valid=1 in that cycle: accept dataIn/isK and encode with the current rd.
  - valid=0: send the fill word for the current rd.
  - The first bit drives tx on the next clock edge (latency 1 clock from accept to line).
  - Back-to-back symbols have no gap. ready pulses every 10*CLK_RATE clocks.
- Encoding: IEEE 802.3 cl.36 tables.
  - D.x.7 uses the alternate A7 form when RD-/x=17,18,20 or RD+/x=11,13,14.
  - rd updates per sub-block: 6b first, then 4b.
  - rd after the symbol is valid when ready next rises.
- Fill symbol: rd toggles if FILL_WORD_FLIP=1, otherwise rd is unchanged.
- Valid K codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
  - Any other isK=1 byte is still consumed (ready handshake completes).
  - The fill word is sent in its place and kError=1 for the accept cycle only.
- txEnable=0 mid-symbol: the current symbol completes.
  - At the slot point, ready stays 0, no data is accepted, and the block goes to IDLE (tx=0).
  - rd is preserved.
- valid asserted with ready=0: no transfer. Source must hold data. No internal buffer.
- rst during a symbol: the line aborts immediately to the reset values.

Test Plan:
1. Reset, txEnable=1, valid=0, CLK_RATE=8 -> tx shows 0011111010 then 1100000101 then 0011111010; each bit held 8 clocks; rd toggles 0->1->0; ready pulses every 80 clocks.
2. rd=0, accept dataIn=8'h00 isK=0 -> tx=1001110100 starting 1 clock after accept; rd stays 0.
3. Accept 8'hB5 (D21.5) at rd=0 and at rd=1 -> tx=1010101010 both times; rd unchanged.
4. Accept 8'hBC isK=1 (K28.5) at rd=0 -> tx=0011111010, rd=1. Then 8'h3C isK=1 (K28.1) -> tx=1100000110, rd=0.
5. Accept 8'h01 isK=1 -> kError high for 1 cycle; fill word sent; next ready pulse 80 clocks later.
6. Hold valid=1 with random bytes, then pulse rst at bit 4 of a symbol -> tx/ready/rd/busy are 0 before the next clk edge. Restart begins a fresh symbol with rd=0. Separately, drop txEnable mid-symbol -> the symbol completes, then tx=0 and ready stays 0.

Source files
------------

// File: rtl/tx8b10b_kchar.sv
// Bit-serial 8b10b transmitter with K-code support and a valid/ready slot handshake.
// Symbols go out MSB first (a..j); idle slots carry the K28.5 fill word.
//
// state | meaning
// IDLE  | transmitter disabled, line held low
// SHIFT | prime cycle (slot only) or shifting a 10-bit symbol

module tx8b10b_kchar #(
  parameter logic [9:0] FILL_WORD_RD0  = 10'b0011111010,
  parameter logic [9:0] FILL_WORD_RD1  = 10'b1100000101,
  parameter logic       FILL_WORD_FLIP = 1'b1,
  parameter int         CLK_RATE       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txEnable,
  input  logic [7:0] dataIn,
  input  logic       isK,
  input  logic       valid,
  output logic       ready,
  output logic       kError,
  output logic       busy,
  output logic       rd,
  output logic       tx
);

  localparam int             TW       = $clog2(CLK_RATE);
  localparam logic [TW-1:0]  TMR_LOAD = TW'(CLK_RATE - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic            prime_q, prime_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [9:0]      shreg_q, shreg_d;
  logic            rd_q, rd_d;

  logic [4:0]      x;
  logic [2:0]      y;
  logic            k_ok;
  logic            slot;
  logic [5:0]      six_m, six_c;
  logic [3:0]      four_m, four_c;
  logic            rd6, alt7;
  logic [9:0]      k_sym_m, enc_sym, fill_sym;
  logic            enc_rd, fill_rd;

  // 5b/6b codes in RD- form (abcdei)
  function automatic logic [5:0] enc6_m(input logic [4:0] v);
    logic [5:0] r;
    r = 6'b000000;
    case (v)
      5'd0:  r = 6'b100111;
      5'd1:  r = 6'b011101;
      5'd2:  r = 6'b101101;
      5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;
      5'd5:  r = 6'b101001;
      5'd6:  r = 6'b011001;
      5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;
      5'd9:  r = 6'b100101;
      5'd10: r = 6'b010101;
      5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;
      5'd13: r = 6'b101100;
      5'd14: r = 6'b011100;
      5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;
      5'd17: r = 6'b100011;
      5'd18: r = 6'b010011;
      5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;
      5'd21: r = 6'b101010;
      5'd22: r = 6'b011010;
      5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;
      5'd25: r = 6'b100110;
      5'd26: r = 6'b010110;
      5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;
      5'd29: r = 6'b101110;
      5'd30: r = 6'b011110;
      5'd31: r = 6'b101011;
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  // 3b/4b data codes in RD- form (fghj), primary D.x.7
  function automatic logic [3:0] enc4_m(input logic [2:0] v);
    logic [3:0] r;
    r = 4'b0000;
    case (v)
      3'd0: r = 4'b1011;
      3'd1: r = 4'b1001;
      3'd2: r = 4'b0101;
      3'd3: r = 4'b1100;
      3'd4: r = 4'b1101;
      3'd5: r = 4'b1010;
      3'd6: r = 4'b0110;
      3'd7: r = 4'b1110;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // 4b half of K codes when the symbol starts at RD-; RD+ form is the full complement
  function automatic logic [3:0] k4_m(input logic [2:0] v);
    logic [3:0] r;
    r = 4'b0000;
    case (v)
      3'd0: r = 4'b0100;
      3'd1: r = 4'b1001;
      3'd2: r = 4'b0101;
      3'd3: r = 4'b0011;
      3'd4: r = 4'b0010;
      3'd5: r = 4'b1010;
      3'd6: r = 4'b0110;
      3'd7: r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  assign x        = dataIn[4:0];
  assign y        = dataIn[7:5];
  assign k_ok     = (x == 5'd28) || (dataIn == 8'hF7) || (dataIn == 8'hFB) ||
                    (dataIn == 8'hFD) || (dataIn == 8'hFE);
  assign six_m    = (isK && (x == 5'd28)) ? 6'b001111 : enc6_m(x);
  assign k_sym_m  = {six_m, k4_m(y)};
  assign fill_sym = rd_q ? FILL_WORD_RD1 : FILL_WORD_RD0;
  assign fill_rd  = FILL_WORD_FLIP ? ~rd_q : rd_q;

  always_comb begin
    six_c = six_m;
    if (rd_q && (($countones(six_m) != 3) || (x == 5'd7)))
      six_c = ~six_m;

    rd6 = rd_q;
    if ($countones(six_c) > 3)
      rd6 = 1'b1;
    else if ($countones(six_c) < 3)
      rd6 = 1'b0;

    // A7 avoids a run of five equal bits across the 6b/4b boundary
    alt7 = (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
           ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    four_m = ((y == 3'd7) && alt7) ? 4'b0111 : enc4_m(y);
    four_c = four_m;
    if (rd6 && (($countones(four_m) != 2) || (y == 3'd3)))
      four_c = ~four_m;

    enc_sym = isK ? (rd_q ? ~k_sym_m : k_sym_m) : {six_c, four_c};
    enc_rd  = rd_q;
    if ($countones(enc_sym) > 5)
      enc_rd = 1'b1;
    else if ($countones(enc_sym) < 5)
      enc_rd = 1'b0;
  end

  assign slot = (state_q == SHIFT) && (prime_q || ((bit_idx_q == 4'd9) && (timer_q == '0)));

  always_comb begin
    state_d   = state_q;
    prime_d   = prime_q;
    bit_idx_d = bit_idx_q;
    timer_d   = timer_q;
    shreg_d   = shreg_q;
    rd_d      = rd_q;
    ready     = 1'b0;
    kError    = 1'b0;

    case (state_q)
      IDLE: begin
        if (txEnable) begin
          state_d = SHIFT;
          prime_d = 1'b1;
        end
      end
      SHIFT: begin
        if (slot) begin
          prime_d = 1'b0;
          if (txEnable) begin
            ready     = 1'b1;
            bit_idx_d = 4'd0;
            timer_d   = TMR_LOAD;
            if (valid && (!isK || k_ok)) begin
              shreg_d = enc_sym;
              rd_d    = enc_rd;
            end else begin
              shreg_d = fill_sym;
              rd_d    = fill_rd;
            end
            kError = valid && isK && !k_ok;
          end else begin
            state_d   = IDLE;
            bit_idx_d = 4'd0;
            timer_d   = '0;
            shreg_d   = '0;
          end
        end else if (timer_q == '0) begin
          timer_d   = TMR_LOAD;
          bit_idx_d = bit_idx_q + 4'd1;
          shreg_d   = {shreg_q[8:0], 1'b0};
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prime_q   <= 1'b0;
      bit_idx_q <= 4'd0;
      timer_q   <= '0;
      shreg_q   <= '0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      prime_q   <= prime_d;
      bit_idx_q <= bit_idx_d;
      timer_q   <= timer_d;
      shreg_q   <= shreg_d;
      rd_q      <= rd_d;
    end
  end

  assign busy = (state_q == SHIFT) && !prime_q;
  assign tx   = busy && shreg_q[9];
  assign rd   = rd_q;

endmodule
